mem_resp_pipe: RTL
==================

// Module: mem_resp_pipe
// PURPOSE
//  Responder end of the processor memory bus (addr/rd_req/wr_req/rd_data/wr_data/busy/ack).
//  Holds a word-addressed 16-bit array and answers each request after LATENCY cycles.
//  Provides an out-of-band (OOB) write port for program load and an OOB read port so
//  benches can dump memory after a run. Sits beside the processor inside the computer top.
// PARAMETERS
//  MEM_ADDR_BITS  8   array depth = 2**MEM_ADDR_BITS words; addr[15:MEM_ADDR_BITS] ignored (wrap)
//  LATENCY        4   cycles from request sample to ack; legal range 1..15
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous reset, active-low
//  addr         in   16  word address, sampled with request
//  rd_req       in   1   read request, 1-cycle pulse
//  wr_req       in   1   write request, 1-cycle pulse
//  wr_data      in   16  write data, sampled with wr_req
//  rd_data      out  16  read data, valid only in ack cycle of a read
//  busy         out  1   request in flight; new requests ignored while high
//  ack          out  1   1-cycle completion pulse
//  oob_wr_addr  in   16  OOB write address (low MEM_ADDR_BITS used)
//  oob_wr_data  in   16  OOB write data
//  oob_wen      in   1   OOB write enable
//  oob_rd_addr  in   16  OOB read address (low MEM_ADDR_BITS used)
//  oob_rd_data  out  16  registered OOB read data, 1-cycle latency
// BEHAVIOUR
//  Reset (rst=0, async): busy=0, ack=0, rd_data=0, oob_rd_data=0, FSM->IDLE, counter=0.
//   Array contents NOT cleared. Reset mid-request aborts it: no ack, pending write dropped.
//  FSM: IDLE -> WAIT -> ACK -> IDLE.
//   IDLE: request accepted at edge N when rd_req|wr_req. Latch addr, op, wr_data.
//    Both high -> treated as write; rd_data stays 0 in its ack cycle.
//    LATENCY=1: go straight to ACK. Otherwise go to WAIT with counter=LATENCY-1.
//   WAIT: busy=1 (cycles N+1..N+LATENCY-1). Decrement counter. At counter==1 go to ACK.
//    rd_req/wr_req ignored, never queued.
//   ACK: cycle N+LATENCY. ack=1, busy=0.
//    Write: array[addr] <= wr_data at end of this cycle.
//    Read: rd_data = array[addr] as of start of this cycle.
//    A new request in the ACK cycle is accepted (back-to-back).
//    Otherwise -> IDLE. Outside ACK, rd_data returns to 0.
//  Read-after-write: a read accepted in a write's ACK cycle sees the new data.
//  OOB write: applied any cycle oob_wen=1, independent of FSM.
//   If it hits the same word as a bus write committing that edge, the bus write wins.
//  OOB read: oob_rd_data <= array[oob_rd_addr] every edge. Pre-edge contents, no bypass.
//  Address wrap: addr 16'h0105 with MEM_ADDR_BITS=8 hits word 8'h05.
// TESTING
//  1 OOB load [3]=16'hBEEF; rd_req addr=3 at edge 0 -> busy edges 1-3, ack+rd_data=BEEF at cycle 4.
//  2 wr_req addr=7 data=1234, then rd_req in ack cycle -> second ack 4 cycles later, rd_data=1234.
//  3 rd_req while busy=1 -> ignored; exactly one ack, for the first request only.
//  4 rd_req+wr_req together, addr=2 data=00AA -> write performed, rd_data=0 at ack; oob_rd [2]=00AA.
//  5 rst low 2 cycles after wr_req addr=9 -> busy/ack=0 at once, no ack; [9] unchanged via OOB read.
//  6 LATENCY=1 and wr addr 16'h0110 (MEM_ADDR_BITS=8) -> ack next cycle, busy never high; oob_rd [0x10] returns data.

Source files
------------

// File: rtl/mem_resp_pipe.sv
// Memory-bus responder: word array answering each request after LATENCY cycles.
// Side ports load and dump the array independently of the bus FSM.
module mem_resp_pipe #(
  parameter int MEM_ADDR_BITS = 8,
  parameter int LATENCY       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        ack,
  input  logic [15:0] oob_wr_addr,
  input  logic [15:0] oob_wr_data,
  input  logic        oob_wen,
  input  logic [15:0] oob_rd_addr,
  output logic [15:0] oob_rd_data
);

  localparam int AW    = MEM_ADDR_BITS;
  localparam int DEPTH = 1 << AW;
  localparam bit LAT1  = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  logic [15:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [15:0]   wdata_q;
  logic          busy_q;
  logic          ack_q;
  logic [15:0]   oob_q;
  logic          accept;
  logic          unused_hi;

  assign unused_hi = ^{addr[15:AW],
                       oob_wr_addr[15:AW],
                       oob_rd_addr[15:AW]};

  // Requests are only heard outside WAIT; ACK allows back-to-back
  assign accept = (rd_req | wr_req) &&
                  (state_q != WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr[AW-1:0];
        wr_q    <= wr_req;
        wdata_q <= wr_data;
      end
      unique case (state_q)
        IDLE, ACK: begin
          if (accept && LAT1) begin
            state_q <= ACK;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
          end else if (accept) begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= ACK;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus write is last so it overrides a same-word OOB write
  always_ff @(posedge clk) begin
    if (oob_wen)
      mem_q[oob_wr_addr[AW-1:0]] <= oob_wr_data;
    if (ack_q && wr_q)
      mem_q[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oob_q <= '0;
    else
      oob_q <= mem_q[oob_rd_addr[AW-1:0]];
  end

  assign rd_data     = (ack_q && !wr_q) ?
                       mem_q[addr_q] : '0;
  assign busy        = busy_q;
  assign ack         = ack_q;
  assign oob_rd_data = oob_q;

endmodule
